// File: rtl/ras_predecode.sv
// Fetch-stage predecoder feeding a return address stack.
// Classifies each accepted instruction as call/return using the RISC-V
// link-register hints, drives combinational RAS push/pop strobes, registers a
// next-PC prediction, and keeps saturating call/return/miss counters.
module ras_predecode #(
  parameter int unsigned DATAWIDTH = 40,
  parameter int unsigned CNTWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATAWIDTH-1:0] i_pc,
  input  logic [31:0]          i_instr,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATAWIDTH-1:0] o_pc,
  output logic [31:0]          o_instr,
  output logic [DATAWIDTH-1:0] o_next_pc,
  output logic                 o_pred_taken,
  output logic                 o_ras_write_en,
  output logic [DATAWIDTH-1:0] o_ras_write_pc,
  output logic                 o_ras_read_en,
  input  logic [DATAWIDTH-1:0] i_ras_read_pc,
  input  logic                 i_ras_empty,
  output logic [CNTWIDTH-1:0]  o_call_cnt,
  output logic [CNTWIDTH-1:0]  o_ret_cnt,
  output logic [CNTWIDTH-1:0]  o_ret_miss_cnt
);

  localparam int unsigned JIMMW = 21;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  logic                 r_alive;
  logic                 r_valid;
  logic [DATAWIDTH-1:0] r_pc;
  logic [31:0]          r_instr;
  logic [DATAWIDTH-1:0] r_next_pc;
  logic                 r_pred_taken;
  logic [CNTWIDTH-1:0]  r_call_cnt;
  logic [CNTWIDTH-1:0]  r_ret_cnt;
  logic [CNTWIDTH-1:0]  r_ret_miss_cnt;

  logic                 w_accept;
  logic [4:0]           w_rd;
  logic [4:0]           w_rs1;
  logic                 w_rd_link;
  logic                 w_rs1_link;
  logic                 w_is_jal;
  logic                 w_is_jalr;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_pop_hit;
  logic [DATAWIDTH-1:0] w_pc_plus4;
  logic [DATAWIDTH-1:0] w_jimm;
  logic [DATAWIDTH-1:0] w_next_pc;
  logic                 w_taken;

  // Output stage accepts when empty or draining; held off until out of reset.
  assign o_ready  = r_alive & (~r_valid | i_ready);
  assign w_accept = i_valid & o_ready & ~i_flush;

  // Decode fields, classify the instruction and form the prediction.
  always_comb begin
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_taken    = 1'b0;
    w_rd       = i_instr[11:7];
    w_rs1      = i_instr[19:15];
    w_rd_link  = (w_rd == 5'd1) || (w_rd == 5'd5);
    w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
    w_is_jal   = (i_instr[6:0] == OPC_JAL);
    w_is_jalr  = (i_instr[6:0] == OPC_JALR) && (i_instr[14:12] == 3'b000);
    w_pc_plus4 = i_pc + DATAWIDTH'(4);
    w_jimm     = {{(DATAWIDTH-JIMMW){i_instr[31]}}, i_instr[31], i_instr[19:12],
                  i_instr[20], i_instr[30:21], 1'b0};
    w_next_pc  = w_pc_plus4;
    if (w_is_jal) begin
      w_push    = w_rd_link;
      w_next_pc = i_pc + w_jimm;
      w_taken   = 1'b1;
    end else if (w_is_jalr) begin
      w_push = w_rd_link;
      w_pop  = w_rs1_link && (!w_rd_link || (w_rs1 != w_rd));
      if (w_pop && !i_ras_empty) begin
        // Top-of-stack is read before any same-cycle push lands.
        w_next_pc = i_ras_read_pc;
        w_taken   = 1'b1;
      end
    end
    w_pop_hit = w_pop & ~i_ras_empty;
  end

  // RAS strobes are qualified by the accept handshake only.
  assign o_ras_write_en = w_accept & w_push;
  assign o_ras_write_pc = w_pc_plus4;
  assign o_ras_read_en  = w_accept & w_pop_hit;

  // Ready enable comes up on the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_alive <= 1'b0;
    else     r_alive <= 1'b1;
  end

  // Single output register stage: load on accept, drop on flush or drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_instr      <= '0;
      r_next_pc    <= '0;
      r_pred_taken <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_pc         <= i_pc;
      r_instr      <= i_instr;
      r_next_pc    <= w_next_pc;
      r_pred_taken <= w_taken;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating statistics counters; flush does not touch them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_call_cnt     <= '0;
      r_ret_cnt      <= '0;
      r_ret_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_push && (r_call_cnt != '1))
        r_call_cnt <= r_call_cnt + CNTWIDTH'(1);
      if (w_pop && (r_ret_cnt != '1))
        r_ret_cnt <= r_ret_cnt + CNTWIDTH'(1);
      if (w_pop && i_ras_empty && (r_ret_miss_cnt != '1))
        r_ret_miss_cnt <= r_ret_miss_cnt + CNTWIDTH'(1);
    end
  end

  assign o_valid        = r_valid;
  assign o_pc           = r_pc;
  assign o_instr        = r_instr;
  assign o_next_pc      = r_next_pc;
  assign o_pred_taken   = r_pred_taken;
  assign o_call_cnt     = r_call_cnt;
  assign o_ret_cnt      = r_ret_cnt;
  assign o_ret_miss_cnt = r_ret_miss_cnt;

endmodule

// File: tb/tb_ras_predecode.sv
// Directed bench for ras_predecode; inputs change on the falling edge,
// strobes are sampled mid-low-phase, registered outputs just after posedge.
module tb_ras_predecode;

  localparam int unsigned DW = 40;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_pc;
  logic [31:0]   i_instr;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_pc;
  logic [31:0]   o_instr;
  logic [DW-1:0] o_next_pc;
  logic          o_pred_taken;
  logic          o_ras_write_en;
  logic [DW-1:0] o_ras_write_pc;
  logic          o_ras_read_en;
  logic [DW-1:0] i_ras_read_pc;
  logic          i_ras_empty;
  logic [CW-1:0] o_call_cnt;
  logic [CW-1:0] o_ret_cnt;
  logic [CW-1:0] o_ret_miss_cnt;

  int checks = 0;
  int errors = 0;
  int wr_pulses;

  always #5 clk = ~clk;

  ras_predecode #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc), .i_instr(i_instr),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_instr(o_instr), .o_next_pc(o_next_pc),
    .o_pred_taken(o_pred_taken), .o_ras_write_en(o_ras_write_en),
    .o_ras_write_pc(o_ras_write_pc), .o_ras_read_en(o_ras_read_en),
    .i_ras_read_pc(i_ras_read_pc), .i_ras_empty(i_ras_empty),
    .o_call_cnt(o_call_cnt), .o_ret_cnt(o_ret_cnt), .o_ret_miss_cnt(o_ret_miss_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an instruction at the falling edge and let combinational logic settle.
  task automatic drive(input logic v, input logic [DW-1:0] pc, input logic [31:0] ins,
                       input logic [DW-1:0] top, input logic empty);
    @(negedge clk);
    i_valid = v; i_pc = pc; i_instr = ins; i_ras_read_pc = top; i_ras_empty = empty;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_pc = '0; i_instr = 32'h0; i_flush = 1'b0;
    i_ready = 1'b1; i_ras_read_pc = '0; i_ras_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'h0);
    chk("rst_o_ready", 64'(o_ready), 64'h0);
    chk("rst_call_cnt", 64'(o_call_cnt), 64'h0);
    chk("rst_next_pc", 64'(o_next_pc), 64'h0);
    @(negedge clk); rst = 1'b0;
    edge_settle();
    chk("post_rst_ready", 64'(o_ready), 64'h1);

    // JAL x1,+0x100 at 0x1000: call
    drive(1'b1, 40'h1000, 32'h100000EF, 40'h0, 1'b0);
    chk("A_wr_en", 64'(o_ras_write_en), 64'h1);
    chk("A_wr_pc", 64'(o_ras_write_pc), 64'h1004);
    chk("A_rd_en", 64'(o_ras_read_en), 64'h0);
    edge_settle();
    chk("A_valid", 64'(o_valid), 64'h1);
    chk("A_next_pc", 64'(o_next_pc), 64'h1100);
    chk("A_taken", 64'(o_pred_taken), 64'h1);
    chk("A_o_pc", 64'(o_pc), 64'h1000);
    chk("A_call_cnt", 64'(o_call_cnt), 64'h1);

    // JALR x0,0(x1) at 0x1100 with top 0x1004: return
    drive(1'b1, 40'h1100, 32'h00008067, 40'h1004, 1'b0);
    chk("B_rd_en", 64'(o_ras_read_en), 64'h1);
    chk("B_wr_en", 64'(o_ras_write_en), 64'h0);
    edge_settle();
    chk("B_next_pc", 64'(o_next_pc), 64'h1004);
    chk("B_taken", 64'(o_pred_taken), 64'h1);
    chk("B_ret_cnt", 64'(o_ret_cnt), 64'h1);

    // JALR x0,0(x5) at 0x2000 with empty RAS: miss
    drive(1'b1, 40'h2000, 32'h00028067, 40'h5555, 1'b1);
    chk("C_rd_en", 64'(o_ras_read_en), 64'h0);
    edge_settle();
    chk("C_next_pc", 64'(o_next_pc), 64'h2004);
    chk("C_taken", 64'(o_pred_taken), 64'h0);
    chk("C_miss_cnt", 64'(o_ret_miss_cnt), 64'h1);
    chk("C_ret_cnt", 64'(o_ret_cnt), 64'h2);

    // JALR x1,0(x5) at 0x3000 with top 0xAAAA: pop+push
    drive(1'b1, 40'h3000, 32'h000280E7, 40'hAAAA, 1'b0);
    chk("D_rd_en", 64'(o_ras_read_en), 64'h1);
    chk("D_wr_en", 64'(o_ras_write_en), 64'h1);
    chk("D_wr_pc", 64'(o_ras_write_pc), 64'h3004);
    edge_settle();
    chk("D_next_pc", 64'(o_next_pc), 64'hAAAA);
    chk("D_taken", 64'(o_pred_taken), 64'h1);
    chk("D_call_cnt", 64'(o_call_cnt), 64'h2);
    chk("D_ret_cnt", 64'(o_ret_cnt), 64'h3);

    // JAL x0,-8 at 0x5000: plain jump, negative immediate
    drive(1'b1, 40'h5000, 32'hFF9FF06F, 40'h0, 1'b0);
    chk("E_wr_en", 64'(o_ras_write_en), 64'h0);
    edge_settle();
    chk("E_next_pc", 64'(o_next_pc), 64'h4FF8);
    chk("E_taken", 64'(o_pred_taken), 64'h1);
    chk("E_call_cnt", 64'(o_call_cnt), 64'h2);

    // JALR x1,0(x1) at 0x6000: same link regs, push only
    drive(1'b1, 40'h6000, 32'h000080E7, 40'h7777, 1'b0);
    chk("F_wr_en", 64'(o_ras_write_en), 64'h1);
    chk("F_rd_en", 64'(o_ras_read_en), 64'h0);
    edge_settle();
    chk("F_next_pc", 64'(o_next_pc), 64'h6004);
    chk("F_taken", 64'(o_pred_taken), 64'h0);
    chk("F_call_cnt", 64'(o_call_cnt), 64'h3);

    // addi at top of PC space: PC+4 wraps
    drive(1'b1, 40'hFF_FFFF_FFFC, 32'h00000013, 40'h0, 1'b0);
    chk("G_wr_en", 64'(o_ras_write_en), 64'h0);
    chk("G_rd_en", 64'(o_ras_read_en), 64'h0);
    edge_settle();
    chk("G_next_pc", 64'(o_next_pc), 64'h0);
    chk("G_taken", 64'(o_pred_taken), 64'h0);

    // JALR x5,0(x1) at 0x7000 with empty RAS: push still happens
    drive(1'b1, 40'h7000, 32'h000082E7, 40'h0, 1'b1);
    chk("H_wr_en", 64'(o_ras_write_en), 64'h1);
    chk("H_rd_en", 64'(o_ras_read_en), 64'h0);
    edge_settle();
    chk("H_next_pc", 64'(o_next_pc), 64'h7004);
    chk("H_call_cnt", 64'(o_call_cnt), 64'h4);
    chk("H_ret_cnt", 64'(o_ret_cnt), 64'h4);
    chk("H_miss_cnt", 64'(o_ret_miss_cnt), 64'h2);

    // Stall 3 cycles with a call waiting, then flush
    @(negedge clk); i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 40'h8000, 32'h100000EF, 40'h0, 1'b0);
      chk("S_ready", 64'(o_ready), 64'h0);
      chk("S_wr_en", 64'(o_ras_write_en), 64'h0);
      chk("S_o_pc", 64'(o_pc), 64'h7000);
      chk("S_valid", 64'(o_valid), 64'h1);
      edge_settle();
    end
    @(negedge clk); i_flush = 1'b1; #1;
    chk("S_flush_wr_en", 64'(o_ras_write_en), 64'h0);
    edge_settle();
    chk("S_flush_valid", 64'(o_valid), 64'h0);
    chk("S_flush_call_cnt", 64'(o_call_cnt), 64'h4);
    @(negedge clk); i_flush = 1'b0; i_ready = 1'b1; i_valid = 1'b0;

    // 20 back-to-back calls: counter saturates at 0xF
    wr_pulses = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 40'h9000 + 40'(4 * k), 32'h100000EF, 40'h0, 1'b0);
      if (o_ras_write_en) wr_pulses++;
    end
    edge_settle();
    chk("SAT_pulses", 64'(wr_pulses), 64'd20);
    chk("SAT_call_cnt", 64'(o_call_cnt), 64'hF);
    chk("SAT_next_pc", 64'(o_next_pc), 64'h9000 + 64'd76 + 64'h100);

    // Reset mid-stall: output dropped, no strobe, counters cleared
    @(negedge clk); i_ready = 1'b0;
    drive(1'b1, 40'hA000, 32'h100000EF, 40'h0, 1'b0);
    @(negedge clk); rst = 1'b1; i_flush = 1'b1; #1;
    chk("R_wr_en", 64'(o_ras_write_en), 64'h0);
    chk("R_valid", 64'(o_valid), 64'h0);
    chk("R_call_cnt", 64'(o_call_cnt), 64'h0);
    edge_settle();
    chk("R_ready", 64'(o_ready), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_predecode.md
Name: ras_predecode

Overview:
- Fetch-stage predecoder that sits directly upstream of the return address stack (RAS) and drives its push/pop ports.
- Accepts one fetched 32-bit instruction per cycle over a valid/ready handshake and classifies it as call, return, both or neither, using the RISC-V link-register hint rules.
- Pushes PC+4 on calls, pops the predicted target on returns, and emits a registered next-PC prediction to the fetch queue.
- Keeps saturating call/return/underflow statistics counters.

Parameters:
- DATAWIDTH, 40: PC width in bits; matches the RAS data width.
- CNTWIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  fetched instruction valid.
- o_ready  out  1  block can accept an instruction this cycle.
- i_pc  in  DATAWIDTH  PC of the fetched instruction.
- i_instr  in  32  instruction word.
- i_flush  in  1  pipeline flush (mispredict/redirect).
- o_valid  out  1  prediction output valid.
- i_ready  in  1  downstream accepts the output.
- o_pc  out  DATAWIDTH  registered instruction PC.
- o_instr  out  32  registered instruction word.
- o_next_pc  out  DATAWIDTH  predicted next PC.
- o_pred_taken  out  1  o_next_pc is a redirect (not PC+4).
- o_ras_write_en  out  1  RAS push.
- o_ras_write_pc  out  DATAWIDTH  value pushed (i_pc+4).
- o_ras_read_en  out  1  RAS pop.
- i_ras_read_pc  in  DATAWIDTH  RAS top-of-stack; combinational read.
- i_ras_empty  in  1  RAS empty flag.
- o_call_cnt, o_ret_cnt, o_ret_miss_cnt  out  CNTWIDTH each  statistics.

Behaviour:
- Reset: asynchronous, active-high. All outputs and internal registers go to 0 on assertion; o_ready goes to 1 on the first cycle after rst deasserts.
- Handshake and latency:
  - accept = i_valid & o_ready & ~i_flush.
  - o_ready = ~o_valid | i_ready, giving a single output register stage with 1-cycle latency.
  - The output register holds stable while o_valid & ~i_ready.
- RAS strobes:
  - Strobes are combinational and asserted only in a cycle where accept=1; they are never asserted while stalled or flushing.
  - o_ras_write_pc = i_pc+4, with modulo 2^DATAWIDTH wrap.
- Classification (link = rd or rs1 in {x1,x5}; opcodes JAL=1101111, JALR=1100111 with funct3=000):
  - JAL with link rd: push. o_next_pc = i_pc + sign-extended J-immediate, o_pred_taken=1.
  - JAL with non-link rd: no RAS op. Target and o_pred_taken=1 as above.
  - JALR, rd link, rs1 not link: push. o_next_pc=i_pc+4, o_pred_taken=0 (target unknown).
  - JALR, rd not link, rs1 link: pop. o_next_pc=i_ras_read_pc, o_pred_taken=1.
  - JALR, both link, rs1!=rd: pop and push in the same cycle. o_next_pc = i_ras_read_pc sampled before the push, o_pred_taken=1.
  - JALR, both link, rs1==rd: push only. o_pred_taken=0.
  - JALR, neither link: no RAS op. o_pred_taken=0.
  - Any other instruction: no RAS op. o_next_pc=i_pc+4, o_pred_taken=0.
- Empty RAS on pop:
  - If i_ras_empty=1 when a pop is required: o_ras_read_en=0, o_next_pc=i_pc+4, o_pred_taken=0, o_ret_miss_cnt increments.
  - A combined pop+push with an empty RAS still performs the push.
- Counters:
  - o_call_cnt increments on each accepted push.
  - o_ret_cnt increments on each accepted pop classification, including misses.
  - All counters saturate at all-ones; no wrap.
- Flush:
  - i_flush=1 clears o_valid on the next edge, drops the buffered output, and blocks acceptance that cycle.
  - RAS contents are not rolled back; recovery is the owner of i_flush's responsibility.
  - Counters are not affected by flush.
- i_flush and rst asserted together: reset dominates.
- Reset mid-stall: the output is dropped and no RAS strobe is issued.

Test Plan:
- Reset, then accept JAL x1,+0x100 at pc=0x1000: o_ras_write_en=1 with 0x1004 in the same cycle. Next cycle o_valid=1, o_next_pc=0x1100, o_pred_taken=1, o_call_cnt=1.
- With RAS holding 0x1004, accept JALR x0,0(x1) at pc=0x1100: o_ras_read_en=1. Next cycle o_next_pc=0x1004, o_pred_taken=1, o_ret_cnt=1.
- Return (JALR x0,0(x5)) with i_ras_empty=1 at pc=0x2000: no read_en, o_next_pc=0x2004, o_pred_taken=0, o_ret_miss_cnt=1.
- JALR x1,0(x5) at pc=0x3000 with top=0xAAAA: read_en=1 and write_en=1 (0x3004) in the same cycle; o_next_pc=0xAAAA.
- Hold i_ready=0 for 3 cycles with i_valid=1: o_ready=0, output held, no RAS strobes. Then i_flush=1: o_valid=0 next cycle.
- Set o_call_cnt near saturation (CNTWIDTH=4) and issue 20 calls: counter stays at 0xF.
